// File: rtl/top_mul_pipe_hs_if.sv
// Valid/ready stream bundle for the pipelined multiplier: operand channel in,
// narrowed product channel out.
interface top_mul_pipe_hs_if #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 26
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, dout_ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, dout_ovf
    );
endinterface

// File: rtl/top_mul_pipe_hs.sv
// Pipelined mixed-sign multiplier with valid/ready flow control and wrap or
// saturating narrowing of the exact product in the last stage.
module top_mul_pipe_hs #(
    parameter int DIN0_WIDTH  = 14,
    parameter int DIN1_WIDTH  = 12,
    parameter int DOUT_WIDTH  = 26,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 3,
    parameter int SATURATE    = 0
) (
    input logic              ap_clk,
    input logic              ap_rst,
    top_mul_pipe_hs_if.slave bus
);

    // One guard bit above the exact D0+D1+1 product keeps every compare in range.
    localparam int N  = NUM_STAGE;
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam bit RS = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic signed [PW-1:0] SMAX = (PW'(1) << (DOUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SMIN = ~SMAX;
    localparam logic signed [PW-1:0] UMAX = (PW'(1) << DOUT_WIDTH) - PW'(1);

    function automatic logic [DOUT_WIDTH:0] narrow(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        logic                 ovf;
        q   = p;
        ovf = 1'b0;
        if (SATURATE != 0) begin
            if (RS) begin
                if (p > SMAX) begin
                    q   = SMAX;
                    ovf = 1'b1;
                end else if (p < SMIN) begin
                    q   = SMIN;
                    ovf = 1'b1;
                end
            end else begin
                if (p[PW-1]) begin
                    q   = '0;
                    ovf = 1'b1;
                end else if (p > UMAX) begin
                    q   = UMAX;
                    ovf = 1'b1;
                end
            end
        end else if (RS) begin
            ovf = (p != {{(PW-DOUT_WIDTH){p[DOUT_WIDTH-1]}}, p[DOUT_WIDTH-1:0]});
        end else begin
            ovf = (p != {{(PW-DOUT_WIDTH){1'b0}}, p[DOUT_WIDTH-1:0]});
        end
        return {ovf, q[DOUT_WIDTH-1:0]};
    endfunction

    logic signed [DIN0_WIDTH:0] ext0;
    logic signed [DIN1_WIDTH:0] ext1;
    logic signed [PW-1:0]       opa;
    logic signed [PW-1:0]       opb;
    logic signed [PW-1:0]       prod_c;

    assign ext0   = {((DIN0_SIGNED != 0) ? bus.din0[DIN0_WIDTH-1] : 1'b0), bus.din0};
    assign ext1   = {((DIN1_SIGNED != 0) ? bus.din1[DIN1_WIDTH-1] : 1'b0), bus.din1};
    assign opa    = PW'(ext0);
    assign opb    = PW'(ext1);
    assign prod_c = opa * opb;

    logic [N-1:0] vld_p;
    logic [N-1:0] ld;
    logic         acc;

    // A stage may load unless it and every stage after it are full and the consumer stalls.
    always_comb begin
        logic full_run;
        full_run = 1'b1;
        ld       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            full_run = full_run & vld_p[k];
            ld[k]    = bus.out_ready | ~full_run;
        end
    end

    assign acc          = bus.in_valid & ld[0];
    assign bus.in_ready = ld[0];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_p <= '0;
        end else begin
            if (ld[0]) vld_p[0] <= acc;
            for (int k = 1; k < N; k++) begin
                if (ld[k]) vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // ---- s1..s(N-1): exact product, loaded only from a valid source ----
    logic signed [PW-1:0] last_in;
    logic                 last_vld;

    generate
        if (N == 1) begin : g_single
            assign last_in  = prod_c;
            assign last_vld = acc;
        end else begin : g_multi
            logic signed [PW-1:0] prod_p [N-1];

            always_ff @(posedge ap_clk) begin
                if (ld[0] && acc) prod_p[0] <= prod_c;
                for (int k = 1; k < N - 1; k++) begin
                    if (ld[k] && vld_p[k-1]) prod_p[k] <= prod_p[k-1];
                end
            end

            assign last_in  = prod_p[N-2];
            assign last_vld = vld_p[N-2];
        end
    endgenerate

    // ---- sN: narrowed result, held while the consumer stalls ----
    logic [DOUT_WIDTH-1:0] dout_p;
    logic                  ovf_p;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            dout_p <= '0;
            ovf_p  <= 1'b0;
        end else if (ld[N-1] && last_vld) begin
            {ovf_p, dout_p} <= narrow(last_in);
        end
    end

    assign bus.out_valid = vld_p[N-1];
    assign bus.dout      = dout_p;
    assign bus.dout_ovf  = ovf_p;

endmodule
